ahb_decoder_pipe: RTL and testbench
===================================

// Module: ahb_decoder_pipe
// PURPOSE
//  Per-master AHB address decoder, parametrised successor of the per-master generated decoder.
//  Decodes the address phase into per-slave requests and registers the data-phase slave select for the response mux.
//  Contains the built-in default slave, which returns the two-cycle ERROR response on unmapped accesses.
//  Sits between one master port and the arbiters/response mux of the AHB interconnect.
// PARAMETERS
//  AHB_ADDR_WIDTH  32          address width
//  SLAVE_NUM       4           number of mapped slaves (1..16)
//  LOW_ADDR        {S*W}       packed array; slave i inclusive low bound at [i*W +: W]; default map below
//  HIGH_ADDR       {S*W}       packed array; slave i inclusive high bound
//                              defaults: s0 0000_0000-0000_03FF, s1 0000_1000-0000_100F,
//                              s2 0000_2404-0000_24FF, s3 0001_0000-0001_FFFF
//  REMAP_SLV       1           slave aliased at address 0 when remap is active (AHB_DEC_REMAP_EN only)
// PORTS
//  hclk             in   1          bus clock
//  hreset_n         in   1          asynchronous active-low reset
//  haddr            in   AW         address-phase address
//  htrans           in   2          htrans_type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//  hready           in   1          bus-level HREADY (from response mux)
//  hreq             out  SLAVE_NUM  address-phase slave request, combinational
//  default_slv_sel  out  1          address phase targets an unmapped region, combinational
//  hsel_dp          out  SLAVE_NUM  registered data-phase slave select, one-hot or zero
//  dflt_sel_dp      out  1          registered: data phase owned by default slave
//  dflt_hready      out  1          default-slave HREADYOUT
//  dflt_hresp       out  1          default-slave HRESP (0 OKAY, 1 ERROR)
//  err_cnt          out  8          saturating count of decode errors
//  hremap           in   1          remap request (present only with AHB_DEC_REMAP_EN)
// BEHAVIOUR
//  - Decode: slave_hit[i] = LOW_ADDR[i] <= haddr <= HIGH_ADDR[i]. Both bounds are inclusive, with unsigned compare.
//  - On overlapping regions the lowest index wins. hreq is therefore one-hot or zero.
//  - Active transfer is htrans==NONSEQ or SEQ.
//  - hreq = slave_hit when htrans!=IDLE, else 0. BUSY still drives hreq so the slave keeps its select.
//  - default_slv_sel = (htrans!=IDLE) & ~|slave_hit.
//  - Data-phase registers update only on the rising hclk edge with hready=1:
//    hsel_dp <= hreq; dflt_sel_dp <= default_slv_sel; trans_dp <= active transfer.
//    While hready=0 they hold.
//  - Default-slave FSM states are OKAY, ERR1, ERR2.
//    OKAY: dflt_hready=1, dflt_hresp=0.
//          Go to ERR1 on an hready=1 edge that captures default_slv_sel=1 with NONSEQ/SEQ.
//          BUSY to an unmapped region stays in OKAY with a zero-wait OKAY response.
//    ERR1: dflt_hready=0, dflt_hresp=1. Always go to ERR2 on the next edge.
//    ERR2: dflt_hready=1, dflt_hresp=1.
//          Go to ERR1 if hready=1 and a new unmapped NONSEQ/SEQ is captured; else go to OKAY.
//  - Error response latency: 2 cycles after the address phase is accepted.
//  - err_cnt increments by 1 on each ERR1 entry and saturates at 8'hFF, no wrap.
//  - Back-to-back unmapped transfers: ERR2 -> ERR1 directly, with no OKAY cycle between them.
//  - Mapped after unmapped: ERR2 -> OKAY; hsel_dp moves to the mapped slave on the same edge.
//  - Async reset (hreset_n=0), including mid-transfer:
//    hsel_dp=0, dflt_sel_dp=0, trans_dp=0, FSM=OKAY (dflt_hready=1, dflt_hresp=0), err_cnt=0.
//    hreq and default_slv_sel follow their inputs combinationally.
// CONFIGURATION
//  Macro AHB_DEC_REMAP_EN.
//  - Defined:
//    - The hremap port exists.
//    - With hremap=1, addresses 0 .. (HIGH_ADDR[REMAP_SLV]-LOW_ADDR[REMAP_SLV]) hit slave REMAP_SLV.
//      This overrides all other slaves. The slave's normal region also stays mapped.
//    - hremap is applied combinationally in the address phase; a change only affects newly decoded addresses.
//  - Undefined: no hremap port, and the plain address map is used.
// TESTING
//  1. Reset: hreset_n=0 mid-ERR1 -> dflt_hready=1, dflt_hresp=0, hsel_dp=0, err_cnt=0 immediately.
//  2. Boundaries: NONSEQ at 0x0000_0000, 0x0000_03FF, 0x0000_2404, 0x0000_24FF -> hreq=0001, 0001, 0100, 0100;
//     0x0000_0400 -> hreq=0000, default_slv_sel=1.
//  3. Error: NONSEQ to 0x0000_0800 with hready=1 ->
//     next cycle dflt_hready=0/dflt_hresp=1; following cycle dflt_hready=1/dflt_hresp=1; err_cnt=1.
//  4. Back-to-back: two unmapped NONSEQs, second accepted in ERR2 -> ERR2 -> ERR1 with no OKAY cycle, err_cnt=2;
//     BUSY to 0x0000_0800 -> OKAY, zero wait.
//  5. Wait states: NONSEQ to s1 (0x0000_1004), then hready=0 for 3 cycles while haddr=0x0001_0000 ->
//     hsel_dp stays 0010; it becomes 1000 only on the edge with hready=1.
//  6. Saturation and remap: 300 unmapped NONSEQs -> err_cnt=8'hFF.
//     With AHB_DEC_REMAP_EN and hremap=1: haddr=0x0000_0008 -> hreq=0010; with hremap=0 -> hreq=0001.

Source files
------------

// File: rtl/ahb_decoder_pipe.sv
// Per-master AHB address decoder: address-phase slave requests, registered data-phase
// selects and a built-in default slave answering unmapped accesses with a two-cycle ERROR.
// Optional hremap aliasing of slave REMAP_SLV at address 0 when AHB_DEC_REMAP_EN is defined.
module ahb_decoder_pipe #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned SLAVE_NUM      = 4,
    parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] LOW_ADDR =
        {32'h0001_0000, 32'h0000_2404, 32'h0000_1000, 32'h0000_0000},
    parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] HIGH_ADDR =
        {32'h0001_FFFF, 32'h0000_24FF, 32'h0000_100F, 32'h0000_03FF}
`ifdef AHB_DEC_REMAP_EN
    ,
    parameter int unsigned REMAP_SLV      = 1
`endif
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]                htrans,
    input  logic                      hready,
`ifdef AHB_DEC_REMAP_EN
    input  logic                      hremap,
`endif
    output logic [SLAVE_NUM-1:0]      hreq,
    output logic                      default_slv_sel,
    output logic [SLAVE_NUM-1:0]      hsel_dp,
    output logic                      dflt_sel_dp,
    output logic                      dflt_hready,
    output logic                      dflt_hresp,
    output logic [7:0]                err_cnt
);

    localparam int unsigned AW = AHB_ADDR_WIDTH;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } dflt_state_e;

`ifdef AHB_DEC_REMAP_EN
    localparam logic [AW-1:0] REMAP_SPAN =
        HIGH_ADDR[REMAP_SLV*AW +: AW] - LOW_ADDR[REMAP_SLV*AW +: AW];
`endif

    logic [SLAVE_NUM-1:0] slave_hit;
    logic [AW-1:0]        offset;
    logic                 addr_valid;
    logic                 active;
    logic                 err_start;

    // Range test as one unsigned compare: an address below LOW wraps to a huge offset.
    // Walking from the top index down lets the lowest matching index win.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slave_hit = '0;
        offset    = '0;
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            offset = haddr - LOW_ADDR[i*AW +: AW];
            if (offset <= (HIGH_ADDR[i*AW +: AW] - LOW_ADDR[i*AW +: AW])) begin
                slave_hit    = '0;
                slave_hit[i] = 1'b1;
            end
        end
`ifdef AHB_DEC_REMAP_EN
        if (hremap && (haddr <= REMAP_SPAN)) begin
            slave_hit            = '0;
            slave_hit[REMAP_SLV] = 1'b1;
        end
`endif
    end

    // BUSY keeps the request asserted so the slave holds its select across the burst.
    assign addr_valid      = (htrans != HTRANS_IDLE);
    assign active          = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign hreq            = addr_valid ? slave_hit : '0;
    assign default_slv_sel = addr_valid & ~|slave_hit;
    assign err_start       = hready & default_slv_sel & active;

    logic [SLAVE_NUM-1:0] hsel_dp_q, hsel_dp_d;
    logic                 dflt_sel_dp_q, dflt_sel_dp_d;
    logic                 trans_dp_q, trans_dp_d;

    always_comb begin
        hsel_dp_d     = hsel_dp_q;
        dflt_sel_dp_d = dflt_sel_dp_q;
        trans_dp_d    = trans_dp_q;
        if (hready) begin
            hsel_dp_d     = hreq;
            dflt_sel_dp_d = default_slv_sel;
            trans_dp_d    = active;
        end
    end

    // NOTE: state is written with non-blocking assignments under an async reset so every
    // register samples the same pre-edge values regardless of block evaluation order.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            hsel_dp_q     <= '0;
            dflt_sel_dp_q <= 1'b0;
            trans_dp_q    <= 1'b0;
        end else begin
            hsel_dp_q     <= hsel_dp_d;
            dflt_sel_dp_q <= dflt_sel_dp_d;
            trans_dp_q    <= trans_dp_d;
        end
    end

    // Data-phase transfer flag is kept for observability only; nothing downstream consumes it.
    logic unused_trans_dp;
    assign unused_trans_dp = trans_dp_q;

    dflt_state_e state_q;
    logic        dflt_hready_q;
    logic        dflt_hresp_q;
    logic [7:0]  err_cnt_q;

    // Default slave: ERR1 stalls with ERROR, ERR2 completes it; ERR2 may chain straight into ERR1.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q       <= ST_OKAY;
            dflt_hready_q <= 1'b1;
            dflt_hresp_q  <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            case (state_q)
                ST_ERR1: begin
                    state_q       <= ST_ERR2;
                    dflt_hready_q <= 1'b1;
                    dflt_hresp_q  <= 1'b1;
                end
                ST_OKAY, ST_ERR2: begin
                    if (err_start) begin
                        state_q       <= ST_ERR1;
                        dflt_hready_q <= 1'b0;
                        dflt_hresp_q  <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else begin
                        state_q       <= ST_OKAY;
                        dflt_hready_q <= 1'b1;
                        dflt_hresp_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_OKAY;
                    dflt_hready_q <= 1'b1;
                    dflt_hresp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hsel_dp     = hsel_dp_q;
    assign dflt_sel_dp = dflt_sel_dp_q;
    assign dflt_hready = dflt_hready_q;
    assign dflt_hresp  = dflt_hresp_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ahb_decoder_pipe.sv
// Self-checking bench for ahb_decoder_pipe: a timeline model of the address map and
// default-slave response compared every cycle, plus directed literal expectations.
module tb_ahb_decoder_pipe;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    localparam logic [31:0] LO [4] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2404, 32'h0001_0000};
    localparam logic [31:0] HI [4] = '{32'h0000_03FF, 32'h0000_100F, 32'h0000_24FF, 32'h0001_FFFF};

    logic        hclk = 1'b0;
    logic        hreset_n = 1'b1;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = IDLE;
    logic        hready = 1'b1;
    logic        hremap = 1'b0;
    logic [3:0]  hreq;
    logic        default_slv_sel;
    logic [3:0]  hsel_dp;
    logic        dflt_sel_dp;
    logic        dflt_hready;
    logic        dflt_hresp;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ahb_decoder_pipe dut (
        .hclk            (hclk),
        .hreset_n        (hreset_n),
        .haddr           (haddr),
        .htrans          (htrans),
        .hready          (hready),
`ifdef AHB_DEC_REMAP_EN
        .hremap          (hremap),
`endif
        .hreq            (hreq),
        .default_slv_sel (default_slv_sel),
        .hsel_dp         (hsel_dp),
        .dflt_sel_dp     (dflt_sel_dp),
        .dflt_hready     (dflt_hready),
        .dflt_hresp      (dflt_hresp),
        .err_cnt         (err_cnt)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
`ifdef AHB_DEC_REMAP_EN
    wire rm_now = hremap;
`else
    wire rm_now = 1'b0;
`endif

    function automatic logic [3:0] exp_hit(input logic [31:0] a, input logic rm);
        logic [3:0] r;
        r = '0;
        if (rm && a <= (HI[1] - LO[1])) return 4'b0010;
        for (int i = 0; i < 4; i++) begin
            if (r == 4'b0000 && a >= LO[i] && a <= HI[i]) r = 4'(1) << i;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_hreq(input logic [31:0] a, input logic [1:0] t, input logic rm);
        return (t != IDLE) ? exp_hit(a, rm) : 4'b0000;
    endfunction

    function automatic logic exp_dflt(input logic [31:0] a, input logic [1:0] t, input logic rm);
        return (t != IDLE) && (exp_hit(a, rm) == 4'b0000);
    endfunction

    // Response timeline: the edge accepting an unmapped NONSEQ/SEQ is m_err_edge; the cycle
    // after it stalls with ERROR, the next completes ERROR, everything else is OKAY.
    logic [3:0] m_hsel = '0;
    logic       m_dsel = 1'b0;
    int         m_edge = 0;
    int         m_err_edge = -100;
    int         m_cnt = 0;

    always @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            m_hsel     <= '0;
            m_dsel     <= 1'b0;
            m_edge     <= 0;
            m_err_edge <= -100;
            m_cnt      <= 0;
        end else begin
            m_edge <= m_edge + 1;
            if (hready) begin
                m_hsel <= exp_hreq(haddr, htrans, rm_now);
                m_dsel <= exp_dflt(haddr, htrans, rm_now);
            end
            if (hready && htrans[1] && exp_dflt(haddr, htrans, rm_now) && (m_edge != m_err_edge)) begin
                m_err_edge <= m_edge + 1;
                m_cnt      <= (m_cnt >= 255) ? 255 : m_cnt + 1;
            end
        end
    end

    always @(negedge hclk) begin
        check("cmp_hreq", 32'(hreq), 32'(exp_hreq(haddr, htrans, rm_now)));
        check("cmp_default_slv_sel", 32'(default_slv_sel), 32'(exp_dflt(haddr, htrans, rm_now)));
        check("cmp_hsel_dp", 32'(hsel_dp), 32'(m_hsel));
        check("cmp_dflt_sel_dp", 32'(dflt_sel_dp), 32'(m_dsel));
        check("cmp_dflt_hready", 32'(dflt_hready), 32'(m_edge != m_err_edge));
        check("cmp_dflt_hresp", 32'(dflt_hresp), 32'((m_edge == m_err_edge) || (m_edge == m_err_edge + 1)));
        check("cmp_err_cnt", 32'(err_cnt), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
        haddr  = a;
        htrans = t;
        hready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge hclk);
        #2;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  req;
        logic        dflt;
    } bvec_t;

    bvec_t bvec [5] = '{
        '{32'h0000_0000, 4'b0001, 1'b0},
        '{32'h0000_03FF, 4'b0001, 1'b0},
        '{32'h0000_2404, 4'b0100, 1'b0},
        '{32'h0000_24FF, 4'b0100, 1'b0},
        '{32'h0000_0400, 4'b0000, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        #1 hreset_n = 1'b0;
        tick();
        tick();
        check("reset_dflt_hready", 32'(dflt_hready), 32'd1);
        check("reset_dflt_hresp", 32'(dflt_hresp), 32'd0);
        check("reset_hsel_dp", 32'(hsel_dp), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        hreset_n = 1'b1;
        tick();

        // Boundaries; the last vector is unmapped and starts an error response.
        foreach (bvec[i]) begin
            drive(bvec[i].addr, NONSEQ, 1'b1);
            check("bound_hreq", 32'(hreq), 32'(bvec[i].req));
            check("bound_default_slv_sel", 32'(default_slv_sel), 32'(bvec[i].dflt));
            tick();
        end
        check("bound_err1_hready", 32'(dflt_hready), 32'd0);
        check("bound_err1_hresp", 32'(dflt_hresp), 32'd1);
        drive(32'h0, IDLE, 1'b0);
        tick();
        drive(32'h0, IDLE, 1'b1);
        tick();
        check("bound_err_cnt", 32'(err_cnt), 32'd1);

        // Single error response timing.
        drive(32'h0000_0800, NONSEQ, 1'b1);
        tick();
        check("err_c1_hready", 32'(dflt_hready), 32'd0);
        check("err_c1_hresp", 32'(dflt_hresp), 32'd1);
        drive(32'h0, IDLE, 1'b0);
        tick();
        check("err_c2_hready", 32'(dflt_hready), 32'd1);
        check("err_c2_hresp", 32'(dflt_hresp), 32'd1);
        check("err_cnt_2", 32'(err_cnt), 32'd2);
        drive(32'h0, IDLE, 1'b1);
        tick();
        check("err_back_okay_hresp", 32'(dflt_hresp), 32'd0);

        // Back-to-back unmapped: second one accepted in ERR2.
        drive(32'h0000_0800, NONSEQ, 1'b1);
        tick();
        drive(32'h0000_0900, NONSEQ, 1'b0);
        tick();
        check("b2b_err2_hready", 32'(dflt_hready), 32'd1);
        check("b2b_err2_hresp", 32'(dflt_hresp), 32'd1);
        drive(32'h0000_0900, NONSEQ, 1'b1);
        tick();
        check("b2b_err1_hready", 32'(dflt_hready), 32'd0);
        check("b2b_err1_hresp", 32'(dflt_hresp), 32'd1);
        check("b2b_err_cnt", 32'(err_cnt), 32'd4);
        drive(32'h0, IDLE, 1'b0);
        tick();
        drive(32'h0000_0800, BUSY, 1'b1);
        check("busy_unmapped_dflt", 32'(default_slv_sel), 32'd1);
        tick();
        check("busy_okay_hready", 32'(dflt_hready), 32'd1);
        check("busy_okay_hresp", 32'(dflt_hresp), 32'd0);
        check("busy_dflt_sel_dp", 32'(dflt_sel_dp), 32'd1);
        check("busy_err_cnt", 32'(err_cnt), 32'd4);

        // Mapped after unmapped: ERR2 -> OKAY with hsel_dp moving on the same edge.
        drive(32'h0000_0800, NONSEQ, 1'b1);
        tick();
        drive(32'h0000_1004, NONSEQ, 1'b0);
        tick();
        drive(32'h0000_1004, NONSEQ, 1'b1);
        tick();
        check("map_after_hsel_dp", 32'(hsel_dp), 32'b0010);
        check("map_after_hresp", 32'(dflt_hresp), 32'd0);
        drive(32'h0000_1004, BUSY, 1'b1);
        check("busy_mapped_hreq", 32'(hreq), 32'b0010);
        drive(32'h0000_1004, IDLE, 1'b1);
        check("idle_hreq", 32'(hreq), 32'b0000);

        // Wait states hold the data-phase select.
        drive(32'h0000_1004, SEQ, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(32'h0001_0000, NONSEQ, 1'b0);
            tick();
            check("wait_hsel_hold", 32'(hsel_dp), 32'b0010);
        end
        drive(32'h0001_0000, NONSEQ, 1'b1);
        tick();
        check("wait_hsel_move", 32'(hsel_dp), 32'b1000);

        // Async reset in the middle of ERR1.
        drive(32'h0000_0800, NONSEQ, 1'b1);
        tick();
        check("pre_reset_hready", 32'(dflt_hready), 32'd0);
        hreset_n = 1'b0;
        #1;
        check("midrst_dflt_hready", 32'(dflt_hready), 32'd1);
        check("midrst_dflt_hresp", 32'(dflt_hresp), 32'd0);
        check("midrst_hsel_dp", 32'(hsel_dp), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_hreq_comb", 32'(default_slv_sel), 32'd1);
        drive(32'h0, IDLE, 1'b1);
        tick();
        hreset_n = 1'b1;
        tick();

        // Saturation: 300 unmapped accesses, each accepted on a ready edge.
        for (int i = 0; i < 300; i++) begin
            drive(32'h0000_0800 + 32'(i), NONSEQ, 1'b1);
            tick();
            drive(32'h0000_0800 + 32'(i), NONSEQ, 1'b0);
            tick();
        end
        drive(32'h0, IDLE, 1'b1);
        tick();
        check("sat_err_cnt", 32'(err_cnt), 32'hFF);
        tick();

`ifdef AHB_DEC_REMAP_EN
        hremap = 1'b1;
        drive(32'h0000_0008, NONSEQ, 1'b1);
        check("remap_on_hreq", 32'(hreq), 32'b0010);
        drive(32'h0000_000F, NONSEQ, 1'b1);
        check("remap_top_hreq", 32'(hreq), 32'b0010);
        drive(32'h0000_0010, NONSEQ, 1'b1);
        check("remap_above_hreq", 32'(hreq), 32'b0001);
        drive(32'h0000_1004, NONSEQ, 1'b1);
        check("remap_orig_hreq", 32'(hreq), 32'b0010);
        tick();
        hremap = 1'b0;
        drive(32'h0000_0008, NONSEQ, 1'b1);
        check("remap_off_hreq", 32'(hreq), 32'b0001);
        tick();
`endif
        drive(32'h0, IDLE, 1'b1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
